// File: rtl/rv32i_mtimer_pkg.sv
// Shared definitions for the rv32i machine timer: register offsets, widths,
// reset values and the bus FSM encoding.
package rv32i_mtimer_pkg;

  localparam int MTIME_W = 48;

  localparam logic [MTIME_W-1:0] MTIMECMP_RESET = 48'hFFFF_FFFF_FFFF;

  localparam logic [4:0] MTIMER_OFF_MTIME_LO    = 5'h00;
  localparam logic [4:0] MTIMER_OFF_MTIME_HI    = 5'h04;
  localparam logic [4:0] MTIMER_OFF_MTIMECMP_LO = 5'h08;
  localparam logic [4:0] MTIMER_OFF_MTIMECMP_HI = 5'h0C;
  localparam logic [4:0] MTIMER_OFF_CTRL        = 5'h10;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } bus_state_t;

  // Anything past CTRL or not word aligned is answered with an error.
  function automatic logic mtimer_addr_err(input logic [4:0] addr);
    return (addr > MTIMER_OFF_CTRL) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/rv32i_mtimer_if.sv
// Simple 32-bit valid/ready register bus used to program the machine timer.
interface rv32i_mtimer_if;

  logic        valid;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output valid, we, addr, wdata,
    input  ready, rdata, err
  );

  modport slave (
    input  valid, we, addr, wdata,
    output ready, rdata, err
  );

endinterface

// File: rtl/rv32i_mtimer_prescaler.sv
// Tick divider for the machine timer: counts 0..DIV-1 while enabled and
// asserts tick on the last count. Holds its phase while disabled.
module rv32i_mtimer_prescaler #(
  parameter int unsigned DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(DIV - 1);

  logic [15:0] count_reg;

  assign tick = en && (count_reg == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= tick ? 16'd0 : count_reg + 16'd1;
    end
  end

endmodule

// File: rtl/rv32i_mtimer.sv
// Memory-mapped 48-bit machine timer with compare interrupt (MTIP).
// Define RV32I_MTIMER_PRESCALE_EN to divide the tick by PRESCALE_DIV.
module rv32i_mtimer
  import rv32i_mtimer_pkg::*;
#(
  parameter int unsigned PRESCALE_DIV = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  rv32i_mtimer_if.slave      bus,
  output logic [MTIME_W-1:0] mtime,
  output logic               timer_interrupt
);

  bus_state_t         state_reg;
  logic [MTIME_W-1:0] mtime_reg;
  logic [MTIME_W-1:0] mtimecmp_reg;
  logic [15:0]        hi_shadow_reg;
  logic               en_reg;
  logic               ready_reg;
  logic               err_reg;
  logic [31:0]        rdata_reg;
  logic               irq_reg;

  logic        accept;
  logic        req_err;
  logic        wr_ok;
  logic        rd_ok;
  logic        ctrl_clr;
  logic        tick_en;
  logic        tick;
  logic [31:0] rd_mux;

  assign accept  = (state_reg == IDLE) && bus.valid;
  assign req_err = mtimer_addr_err(bus.addr);
  assign wr_ok   = accept && bus.we && !req_err;
  assign rd_ok   = accept && !bus.we && !req_err;

  // A CTRL write that clears EN takes effect in its own cycle, so that tick is lost.
  assign ctrl_clr = wr_ok && (bus.addr == MTIMER_OFF_CTRL) && !bus.wdata[0];
  assign tick_en  = en_reg && !ctrl_clr;

`ifdef RV32I_MTIMER_PRESCALE_EN
  rv32i_mtimer_prescaler #(
    .DIV (PRESCALE_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick_en),
    .tick  (tick)
  );
`else
  logic unused_prescale_div;
  assign unused_prescale_div = ^PRESCALE_DIV;
  assign tick = tick_en;
`endif

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      MTIMER_OFF_MTIME_LO:    rd_mux = mtime_reg[31:0];
      MTIMER_OFF_MTIME_HI:    rd_mux = {16'd0, hi_shadow_reg};
      MTIMER_OFF_MTIMECMP_LO: rd_mux = mtimecmp_reg[31:0];
      MTIMER_OFF_MTIMECMP_HI: rd_mux = {16'd0, mtimecmp_reg[47:32]};
      MTIMER_OFF_CTRL:        rd_mux = {31'd0, en_reg};
      default:                rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      ready_reg     <= 1'b0;
      err_reg       <= 1'b0;
      rdata_reg     <= '0;
      mtime_reg     <= '0;
      mtimecmp_reg  <= MTIMECMP_RESET;
      hi_shadow_reg <= '0;
      en_reg        <= 1'b1;
      irq_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg <= accept ? RESP : IDLE;
          ready_reg <= accept;
          err_reg   <= accept && req_err;
          rdata_reg <= rd_ok ? rd_mux : 32'd0;
        end
        RESP: begin
          state_reg <= IDLE;
          ready_reg <= 1'b0;
          err_reg   <= 1'b0;
          rdata_reg <= '0;
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b0;
          err_reg   <= 1'b0;
          rdata_reg <= '0;
        end
      endcase

      // Bus writes to either half beat the tick; the other half keeps its pre-tick value.
      if (wr_ok && (bus.addr == MTIMER_OFF_MTIME_LO)) begin
        mtime_reg <= {mtime_reg[47:32], bus.wdata};
      end else if (wr_ok && (bus.addr == MTIMER_OFF_MTIME_HI)) begin
        mtime_reg <= {bus.wdata[15:0], mtime_reg[31:0]};
      end else if (tick) begin
        mtime_reg <= mtime_reg + 48'd1;
      end

      if (wr_ok && (bus.addr == MTIMER_OFF_MTIMECMP_LO)) begin
        mtimecmp_reg[31:0] <= bus.wdata;
      end
      if (wr_ok && (bus.addr == MTIMER_OFF_MTIMECMP_HI)) begin
        mtimecmp_reg[47:32] <= bus.wdata[15:0];
      end
      if (wr_ok && (bus.addr == MTIMER_OFF_CTRL)) begin
        en_reg <= bus.wdata[0];
      end

      if (rd_ok && (bus.addr == MTIMER_OFF_MTIME_LO)) begin
        hi_shadow_reg <= mtime_reg[47:32];
      end

      irq_reg <= (mtime_reg >= mtimecmp_reg);
    end
  end

  assign bus.ready       = ready_reg;
  assign bus.err         = err_reg;
  assign bus.rdata       = rdata_reg;
  assign mtime           = mtime_reg;
  assign timer_interrupt = irq_reg;

endmodule

// File: tb/tb_rv32i_mtimer.sv
// Directed self-checking bench for rv32i_mtimer (default build and prescaler build).
module tb_rv32i_mtimer;
  import rv32i_mtimer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [47:0] mtime;
  logic        timer_interrupt;

  int n_vec = 0;
  int n_bad = 0;

  rv32i_mtimer_if bus ();

  rv32i_mtimer #(
    .PRESCALE_DIV (10)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .mtime           (mtime),
    .timer_interrupt (timer_interrupt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic bus_xfer(input logic we, input logic [4:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
    @(negedge clk);
    bus.valid = 1'b1;
    bus.we    = we;
    bus.addr  = addr;
    bus.wdata = wdata;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    bus.we    = 1'b0;
    @(negedge clk);
    check("bus_ready", bus.ready, 1);
    rdata = bus.rdata;
    err   = bus.err;
    $display("bus %s @0x%02h wdata=0x%08h rdata=0x%08h err=%0b",
             we ? "WR" : "RD", addr, wdata, rdata, err);
  endtask

  task automatic wr(input logic [4:0] addr, input logic [31:0] wdata);
    logic [31:0] rdata;
    logic        err;
    bus_xfer(1'b1, addr, wdata, rdata, err);
    check("wr_err", err, 0);
  endtask

  task automatic rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    logic [31:0] rdata;
    logic        err;
    bus_xfer(1'b0, addr, 32'd0, rdata, err);
    check(tag, rdata, exp);
    check("rd_err", err, 0);
  endtask

  task automatic bad_xfer(input string tag, input logic we, input logic [4:0] addr,
                          input logic [31:0] wdata);
    logic [31:0] rdata;
    logic        err;
    bus_xfer(we, addr, wdata, rdata, err);
    check({tag, "_err"}, err, 1);
    check({tag, "_rdata"}, rdata, 0);
  endtask

  task automatic wait_mtime(input string tag, input logic [47:0] target, input int exp_cycles);
    int k;
    k = 0;
    while (mtime !== target && k < 100) begin
      @(negedge clk);
      k++;
    end
    check(tag, k, exp_cycles);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    bus.valid = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mtime", mtime, 0);
    check("rst_irq", timer_interrupt, 0);
    check("rst_ready", bus.ready, 0);
    rst_n = 1'b1;

`ifdef RV32I_MTIMER_PRESCALE_EN
    // Phase starts at 0 on release: increments land every 10th edge.
    wait_mtime("pre_period1", 48'd1, 10);
    wait_mtime("pre_period2", 48'd2, 10);
    wr(MTIMER_OFF_CTRL, 32'd0);
    repeat (35) @(negedge clk);
    check("pre_frozen", mtime, 2);
    // Phase was frozen at 1, so 9 more enabled edges reach the next tick.
    wr(MTIMER_OFF_CTRL, 32'd1);
    wait_mtime("pre_resume", 48'd3, 9);
`endif

    rd("rst_cmp_lo", MTIMER_OFF_MTIMECMP_LO, 32'hFFFF_FFFF);
    rd("rst_cmp_hi", MTIMER_OFF_MTIMECMP_HI, 32'h0000_FFFF);
    rd("rst_ctrl", MTIMER_OFF_CTRL, 32'h1);

`ifndef RV32I_MTIMER_PRESCALE_EN
    // Compare interrupt rise and fall.
    wr(MTIMER_OFF_CTRL, 32'd0);
    wr(MTIMER_OFF_MTIME_HI, 32'd0);
    wr(MTIMER_OFF_MTIME_LO, 32'd0);
    check("set_mtime0", mtime, 0);
    wr(MTIMER_OFF_MTIMECMP_HI, 32'd0);
    wr(MTIMER_OFF_MTIMECMP_LO, 32'd20);
    check("irq_below", timer_interrupt, 0);
    wr(MTIMER_OFF_CTRL, 32'd1);
    check("en_first", mtime, 0);
    wait_mtime("reach20", 48'd20, 20);
    check("irq_at20", timer_interrupt, 0);
    @(negedge clk);
    check("irq_rise", timer_interrupt, 1);
    check("mtime21", mtime, 21);
    wr(MTIMER_OFF_MTIMECMP_LO, 32'd1000);
    check("irq_hold", timer_interrupt, 1);
    @(negedge clk);
    check("irq_fall", timer_interrupt, 0);

    // 48-bit wrap.
    wr(MTIMER_OFF_CTRL, 32'd0);
    wr(MTIMER_OFF_MTIME_HI, 32'h0000_FFFF);
    wr(MTIMER_OFF_MTIME_LO, 32'hFFFF_FFFE);
    check("wrap_set", mtime, 48'hFFFF_FFFF_FFFE);
    wr(MTIMER_OFF_CTRL, 32'd1);
    check("wrap_t0", mtime, 48'hFFFF_FFFF_FFFE);
    @(negedge clk);
    check("wrap_t1", mtime, 48'hFFFF_FFFF_FFFF);
    @(negedge clk);
    check("wrap_t2", mtime, 48'h0);

    // LO read right at the 32-bit carry; HI must come from the snapshot.
    wr(MTIMER_OFF_CTRL, 32'd0);
    wr(MTIMER_OFF_MTIME_HI, 32'd0);
    wr(MTIMER_OFF_MTIME_LO, 32'hFFFF_FFFE);
    wr(MTIMER_OFF_CTRL, 32'd1);
    rd("carry_lo", MTIMER_OFF_MTIME_LO, 32'hFFFF_FFFF);
    check("carry_live", mtime, 48'h1_0000_0000);
    rd("carry_hi_shadow", MTIMER_OFF_MTIME_HI, 32'h0);

    // Writes colliding with ticks.
    wr(MTIMER_OFF_CTRL, 32'd0);
    wr(MTIMER_OFF_MTIME_HI, 32'd3);
    wr(MTIMER_OFF_MTIME_LO, 32'h100);
    wr(MTIMER_OFF_CTRL, 32'd1);
    wr(MTIMER_OFF_MTIME_LO, 32'd5);
    check("tickwr_lo", mtime, 48'h3_0000_0005);
    @(negedge clk);
    check("tickwr_next", mtime, 48'h3_0000_0006);
    wr(MTIMER_OFF_CTRL, 32'd0);
    check("ctrl_suppress", mtime, 48'h3_0000_0007);
    @(negedge clk);
    check("ctrl_hold", mtime, 48'h3_0000_0007);
`endif

    // Error responses leave state untouched.
    wr(MTIMER_OFF_CTRL, 32'd0);
    wr(MTIMER_OFF_MTIME_HI, 32'h12);
    wr(MTIMER_OFF_MTIME_LO, 32'h3456);
    wr(MTIMER_OFF_MTIMECMP_LO, 32'h55);
    check("err_pre", mtime, 48'h12_0000_3456);
    bad_xfer("rd14", 1'b0, 5'h14, 32'd0);
    bad_xfer("rd02", 1'b0, 5'h02, 32'd0);
    bad_xfer("wr14", 1'b1, 5'h14, 32'hFFFF_FFFF);
    bad_xfer("wr01", 1'b1, 5'h01, 32'd0);
    bad_xfer("wr0a", 1'b1, 5'h0A, 32'd0);
    bad_xfer("wr11", 1'b1, 5'h11, 32'd1);
    check("err_mtime", mtime, 48'h12_0000_3456);
    rd("err_cmp_lo", MTIMER_OFF_MTIMECMP_LO, 32'h55);
    rd("err_ctrl", MTIMER_OFF_CTRL, 32'h0);

    // Reset during RESP: no response, everything back to reset values.
    @(negedge clk);
    bus.valid = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = MTIMER_OFF_MTIMECMP_LO;
    bus.wdata = 32'd7;
    @(posedge clk);
    #1;
    bus.valid = 1'b0;
    bus.we    = 1'b0;
    rst_n     = 1'b0;
    @(negedge clk);
    check("rstmid_ready", bus.ready, 0);
    check("rstmid_mtime", mtime, 0);
    check("rstmid_irq", timer_interrupt, 0);
    @(negedge clk);
    check("rstmid_ready2", bus.ready, 0);
    rst_n = 1'b1;
    rd("rstmid_cmp_lo", MTIMER_OFF_MTIMECMP_LO, 32'hFFFF_FFFF);
    rd("rstmid_cmp_hi", MTIMER_OFF_MTIMECMP_HI, 32'h0000_FFFF);
    rd("rstmid_ctrl", MTIMER_OFF_CTRL, 32'h1);
    rd("rstmid_shadow", MTIMER_OFF_MTIME_HI, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rv32i_mtimer.md
# rv32i_mtimer

Memory-mapped machine timer that produces the 48-bit `mtime` count and the `timer_interrupt` (MTIP) level consumed by the core's CSR file. Software programs `mtime`/`mtimecmp` through a simple 32-bit valid/ready bus port. The interrupt is a level that is held while `mtime >= mtimecmp`. The block sits on the peripheral bus next to the core and drives the CSR file's counter and interrupt inputs directly.

## Interface
- `PRESCALE_DIV`, default 10: clk cycles per `mtime` increment. Used only when the prescaler is compiled in. Legal range is 1..65535.
- `clk  in  1`: single clock.
- `rst_n  in  1`: asynchronous, active-low reset.
- `bus_valid  in  1`: request valid. Held by the initiator until `bus_ready`.
- `bus_we  in  1`: 1 = write, 0 = read.
- `bus_addr  in  5`: byte offset within the block.
- `bus_wdata  in  32`: write data. Full-word writes only.
- `bus_ready  out  1`: one-cycle response strobe.
- `bus_rdata  out  32`: read data. Valid only while `bus_ready`=1, otherwise 0.
- `bus_err  out  1`: error response. Qualified by `bus_ready`.
- `mtime  out  48`: current counter value, to the CSR `mtime` input.
- `timer_interrupt  out  1`: MTIP level, to the CSR file.

## Operation
- Register map (byte offsets):
  - 0x00 `MTIME_LO` = mtime[31:0].
  - 0x04 `MTIME_HI` = mtime[47:32] in bits [15:0].
  - 0x08 `MTIMECMP_LO`.
  - 0x0C `MTIMECMP_HI` in bits [15:0].
  - 0x10 `CTRL`: bit0 = EN (count enable).
  - Unused bits read 0 and are ignored on write.
- Reset values:
  - mtime = 0.
  - mtimecmp = 48'hFFFF_FFFF_FFFF.
  - CTRL.EN = 1.
  - hi shadow = 0.
  - All outputs 0.
- Counting: while EN=1, mtime increments by 1 on each tick and wraps from 48'hFFFF_FFFF_FFFF to 0. While EN=0, mtime and the prescaler hold their values.
- Atomic 48-bit read: reading `MTIME_LO` copies mtime[47:32] into a 16-bit hi shadow in the same cycle. Reading `MTIME_HI` returns the shadow, not the live value.
- Interrupt: `timer_interrupt` is registered as (mtime >= mtimecmp), unsigned 48-bit compare. It is independent of EN.
- Bus FSM, two states:
  - IDLE: `bus_valid` accepts the request. Writes are performed and read data is captured in this cycle. Go to RESP.
  - RESP: `bus_ready`=1 for exactly one cycle, then return to IDLE. `bus_valid` seen in RESP is ignored. The initiator deasserts or presents a new request the cycle after `bus_ready`.
- Errors: offset > 0x10 or bus_addr[1:0] != 0 gives `bus_err`=1 with `bus_ready`, rdata 0, and no state change.
- Simultaneous events:
  - A bus write to `MTIME_*` in the same cycle as a tick wins. The written half takes the written value; the other half keeps its pre-tick value, with no increment carried.
  - A bus write to `CTRL` clearing EN in a tick cycle suppresses that tick.
- Reset mid-transaction: the FSM returns to IDLE and all registers go to their reset values. A pending request gets no response and must be reissued.

## Timing
- Bus latency: request accepted at edge N gives `bus_ready` high during cycle N+1. Throughput is one transaction per 2 cycles.
- A write is visible on `mtime`/internal registers the cycle after acceptance, i.e. coincident with `bus_ready`.
- `mtime` updates on the clock edge at which the tick is asserted.
- `timer_interrupt` rises 1 cycle after the register state first satisfies mtime >= mtimecmp. It falls 1 cycle after a `mtimecmp` write makes the compare false.
- The CSR file adds one further cycle before MIP.MTIP is set.

## Configuration
- `RV32I_MTIMER_PRESCALE_EN` defined:
  - A prescaler counts 0..PRESCALE_DIV-1 while EN=1.
  - The tick asserts when the count equals PRESCALE_DIV-1; the count then returns to 0.
  - PRESCALE_DIV=1 gives a tick every cycle.
  - The prescaler resets to 0 and holds while EN=0.
- Not defined: the tick is EN itself (increment every cycle), no prescaler logic exists, and PRESCALE_DIV is ignored.

## Structure
- `rv32i_mtimer_pkg` contains:
  - Offset localparams (`MTIMER_OFF_MTIME_LO` … `MTIMER_OFF_CTRL`).
  - `MTIME_W`=48.
  - `MTIMECMP_RESET`=48'hFFFF_FFFF_FFFF.
  - The bus FSM state encoding (IDLE, RESP).
- Sub-module `rv32i_mtimer_prescaler` (clk, rst_n, en → tick) is instantiated only under the macro.

## Test plan
- Reset → mtime=0, timer_interrupt=0, read 0x08/0x0C returns 0xFFFFFFFF/0x0000FFFF, read 0x10 returns 0x1.
- Macro off: write MTIMECMP_HI=0 then MTIMECMP_LO=20 → timer_interrupt rises exactly 1 cycle after mtime reaches 20. Then write MTIMECMP_LO=1000 → falls 1 cycle after the write.
- Macro on with PRESCALE_DIV=10: mtime increments once per 10 clk cycles. CTRL=0 for 35 cycles → mtime and prescaler frozen. CTRL=1 → counting resumes from the frozen phase.
- Write MTIME_HI=0xFFFF and MTIME_LO=0xFFFFFFFE with macro off → wraps to 0 after 2 ticks. Read LO during the carry then read HI → HI equals the snapshot taken at the LO read.
- Read offset 0x14 and offset 0x02 → bus_ready=1, bus_err=1, rdata=0, no register changes. Write to 0x14 → no register changes.
- Write MTIME_LO=5 in a tick cycle → mtime[31:0]=5 the next cycle, no increment. Assert rst_n low during RESP → bus_ready never pulses and all values return to reset.
